// File: rtl/kvz_cmd_pio_pkg.sv
// Shared definitions for the Kvazaar command output PIO: FSM states,
// register map and capture/mask bit positions.
package kvz_cmd_pio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE
    } kvz_cmd_state_e;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAPT = 2'd3;

    localparam int unsigned BIT_DONE = 0;
    localparam int unsigned BIT_ERR  = 1;

endpackage

// File: rtl/kvz_sync2.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module kvz_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/kvz_cmd_pio_out.sv
// Avalon-MM command output PIO driving a four-phase req/ack handshake.
// Optional handshake timeout is compiled in with KVZ_CMD_TIMEOUT_EN.
module kvz_cmd_pio_out
    import kvz_cmd_pio_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    output logic [WIDTH-1:0] out_data,
    output logic             out_req,
    input  logic             in_ack
);

`ifdef KVZ_CMD_TIMEOUT_EN
    localparam logic [1:0] IRQ_BITS = 2'b11;
`else
    localparam logic [1:0] IRQ_BITS = 2'b01;
`endif

    kvz_cmd_state_e state, state_next;
    logic           ack_s;
    logic           wr;
    logic           start_req;
    logic           busy;
    logic           done_set;
    logic           err_set;
    logic           timeout;
    logic [1:0]     mask;
    logic [1:0]     capture;
    logic [1:0]     capt_clr;
    logic           unused_cfg;

    assign unused_cfg = ^{writedata, 32'(TIMEOUT_CYCLES)};

    kvz_sync2 u_ack_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_ack),
        .q       (ack_s)
    );

    assign wr        = chipselect & ~write_n;
    assign start_req = wr && (address == ADDR_CTRL) && writedata[0];
    assign busy      = (state != IDLE);
    assign out_req   = (state == REQ);
    assign irq       = |(capture & mask);
    assign capt_clr  = (wr && (address == ADDR_CAPT)) ? writedata[1:0] : 2'b00;

`ifdef KVZ_CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign timeout = busy && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_set   = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE:    if (start_req) state_next = REQ;
            REQ:     if (ack_s) state_next = RELEASE;
            RELEASE: begin
                if (!ack_s) begin
                    state_next = IDLE;
                    done_set   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // An expired handshake abandons the transfer: error only, never done.
        if (timeout) begin
            state_next = IDLE;
            done_set   = 1'b0;
            err_set    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data <= '0;
            mask     <= '0;
            capture  <= '0;
            readdata <= '0;
        end else begin
            if (wr && (address == ADDR_DATA) && !busy) begin
                out_data <= writedata[WIDTH-1:0];
            end
            if (wr && (address == ADDR_MASK)) begin
                mask <= writedata[1:0] & IRQ_BITS;
            end
            // Set is OR'ed after the clear so a coincident set wins.
            capture <= ((capture & ~capt_clr) | {err_set, done_set}) & IRQ_BITS;
            case (address)
                ADDR_DATA: readdata <= 32'(out_data);
                ADDR_CTRL: readdata <= {30'd0, capture[BIT_ERR], busy};
                ADDR_MASK: readdata <= {30'd0, mask};
                default:   readdata <= {30'd0, capture};
            endcase
        end
    end

endmodule

// File: tb/tb_kvz_cmd_pio_out.sv
// Directed self-checking bench for kvz_cmd_pio_out (register vectors plus
// handshake, busy, set/clear collision, timeout and mid-handshake reset).
module tb_kvz_cmd_pio_out;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [7:0]  out_data;
    logic        out_req;
    logic        in_ack;

    int total = 0;
    int bad   = 0;

`ifdef KVZ_CMD_TIMEOUT_EN
    localparam logic [31:0] MASK_RB = 32'd3;
`else
    localparam logic [31:0] MASK_RB = 32'd1;
`endif

    kvz_cmd_pio_out #(
        .WIDTH          (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .out_data   (out_data),
        .out_req    (out_req),
        .in_ack     (in_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          do_wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [7:0]  exp_od;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    logic [31:0] r;
    int          cnt;

    initial begin
        vecs[0] = '{1'b1, 2'd0, 32'h0000_00A5, 32'h0000_00A5, 8'hA5};
        vecs[1] = '{1'b1, 2'd2, 32'h0000_0003, MASK_RB,       8'hA5};
        vecs[2] = '{1'b1, 2'd0, 32'h0000_01FF, 32'h0000_00FF, 8'hFF};
        vecs[3] = '{1'b0, 2'd1, 32'h0000_0000, 32'h0000_0000, 8'hFF};
        vecs[4] = '{1'b1, 2'd2, 32'h0000_0000, 32'h0000_0000, 8'hFF};
        vecs[5] = '{1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000, 8'hFF};
        vecs[6] = '{1'b1, 2'd1, 32'h0000_0002, 32'h0000_0000, 8'hFF};
        vecs[7] = '{1'b1, 2'd3, 32'h0000_0003, 32'h0000_0000, 8'hFF};
        vecs[8] = '{1'b1, 2'd0, 32'hFFFF_FF5A, 32'h0000_005A, 8'h5A};

        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_ack     = 1'b0;
        #12;
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_req", {31'd0, out_req}, 32'd0);
        #10 reset_n = 1'b1;
        tick();

        // Register vectors
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, r);
            check($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
            check($sformatf("vec%0d_out_data", i), {24'd0, out_data}, {24'd0, vecs[i].exp_od});
            check($sformatf("vec%0d_out_req", i), {31'd0, out_req}, 32'd0);
        end

        // Normal handshake
        wr(2'd2, 32'd1);
        wr(2'd1, 32'd1);
        check("hs_req_rise", {31'd0, out_req}, 32'd1);
        repeat (4) tick();
        in_ack = 1'b1;
        tick();
        check("hs_req_k", {31'd0, out_req}, 32'd1);
        tick();
        check("hs_req_k1", {31'd0, out_req}, 32'd1);
        tick();
        check("hs_req_k2", {31'd0, out_req}, 32'd0);
        tick();
        tick();
        address = 2'd3;
        in_ack  = 1'b0;
        tick();
        check("hs_irq_m", {31'd0, irq}, 32'd0);
        tick();
        check("hs_irq_m1", {31'd0, irq}, 32'd0);
        tick();
        check("hs_irq_m2", {31'd0, irq}, 32'd1);
        tick();
        check("hs_capt_rd", readdata, 32'd1);
        wr(2'd3, 32'd1);
        check("hs_irq_clr", {31'd0, irq}, 32'd0);

        // Busy protection
        wr(2'd0, 32'h11);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h3C);
        check("busy_out_data", {24'd0, out_data}, 32'h11);
        wr(2'd1, 32'd1);
        rd(2'd1, r);
        check("busy_ctrl", r, 32'd1);
        in_ack = 1'b1;
        repeat (3) tick();
        check("busy_req_fall", {31'd0, out_req}, 32'd0);
        in_ack = 1'b0;
        repeat (3) tick();
        check("busy_done_irq", {31'd0, irq}, 32'd1);
        repeat (3) tick();
        check("busy_single_hs", {31'd0, out_req}, 32'd0);
        wr(2'd3, 32'd1);

        // Done set on the same edge as its W1C
        wr(2'd1, 32'd1);
        in_ack = 1'b1;
        repeat (3) tick();
        in_ack = 1'b0;
        tick();
        tick();
        check("coll_irq_pre", {31'd0, irq}, 32'd0);
        wr(2'd3, 32'd1);
        check("coll_irq", {31'd0, irq}, 32'd1);
        rd(2'd3, r);
        check("coll_capt", r, 32'd1);
        wr(2'd3, 32'd3);

`ifdef KVZ_CMD_TIMEOUT_EN
        wr(2'd2, 32'd1);
        wr(2'd1, 32'd1);
        repeat (15) tick();
        check("to_req_15", {31'd0, out_req}, 32'd1);
        tick();
        check("to_req_16", {31'd0, out_req}, 32'd0);
        check("to_irq_masked", {31'd0, irq}, 32'd0);
        rd(2'd3, r);
        check("to_capt", r, 32'd2);
        rd(2'd1, r);
        check("to_ctrl", r, 32'd2);
        wr(2'd2, 32'd2);
        check("to_irq_unmasked", {31'd0, irq}, 32'd1);
        wr(2'd3, 32'd2);
        check("to_irq_clr", {31'd0, irq}, 32'd0);
`else
        wr(2'd1, 32'd1);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (out_req) cnt++;
            tick();
        end
        check("noto_req_held", cnt, 32'd1000);
        rd(2'd3, r);
        check("noto_capt", r, 32'd0);
        in_ack = 1'b1;
        repeat (3) tick();
        in_ack = 1'b0;
        repeat (3) tick();
        wr(2'd3, 32'd3);
`endif

        // Reset in the middle of a handshake
        wr(2'd1, 32'd1);
        check("rstmid_req", {31'd0, out_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rstmid_req_async", {31'd0, out_req}, 32'd0);
        tick();
        #2 reset_n = 1'b1;
        tick();
        rd(2'd1, r);
        check("rstmid_ctrl", r, 32'd0);
        rd(2'd3, r);
        check("rstmid_capt", r, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
